// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame state encoding, data width and parity helper
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with wrap-bit pointers and occupancy output
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [UART_DATA_BITS-1:0] i_data,
  input  logic                      i_pop,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic [LW-1:0]             o_level
);
  logic [AW:0] r_wr, r_rd;
  logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
  logic w_full, w_empty, w_push, w_pop;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;
  assign o_level = r_wr - r_rd;
  assign o_data  = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered UART transmitter with CTS-gated frame starts
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tx_data_i,
  input  logic          tx_valid_i,
  output logic          tx_ready_o,
  output logic          uart_tx,
  input  logic          uart_cts,
  output logic          busy_o,
  output logic [LW-1:0] fifo_level_o
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int NW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [NW-1:0] BIT_MAX = NW'(UART_DATA_BITS - 1);
  uart_tx_state_e r_state;
  logic r_cts_meta, r_cts_sync, r_par, r_tx;
  logic [BW-1:0] r_baud;
  logic [NW-1:0] r_bit;
  logic [UART_DATA_BITS-1:0] r_shift, w_rd_data;
  logic [LW-1:0] w_level;
  logic w_push, w_last, w_go, w_pop;
  assign fifo_level_o = w_level;
  assign tx_ready_o   = w_level < LW'(FIFO_DEPTH);
  assign w_push       = tx_valid_i && tx_ready_o;
  assign w_last       = r_baud == BAUD_MAX;
  assign w_go         = (w_level != '0) && !r_cts_sync;
  assign w_pop        = w_go && (r_state == IDLE || (r_state == STOP && w_last));
  assign busy_o       = (r_state != IDLE) || (w_level != '0);
  assign uart_tx      = r_tx;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (tx_data_i),
    .i_pop   (w_pop),
    .o_data  (w_rd_data),
    .o_level (w_level)
  );
  // uart_tx is registered from the current state, so the line lags the FSM by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_cts_meta <= uart_cts;
      r_cts_sync <= r_cts_meta;
      r_tx       <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : (r_state == PARITY) ? r_par : 1'b1;
      r_baud     <= (r_state == IDLE || w_last) ? '0 : r_baud + BW'(1);
      if (w_pop) begin
        r_shift <= w_rd_data;
        r_par   <= uart_parity(w_rd_data, PARITY_ODD != 0);
      end
      if (r_state == DATA && w_last) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + NW'(1);
      end
      case (r_state)
        IDLE:    if (w_go) r_state <= START;
        START:   if (w_last) r_state <= DATA;
        DATA:    if (w_last && r_bit == BIT_MAX) r_state <= (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  if (w_last) r_state <= STOP;
        STOP:    if (w_last) r_state <= w_go ? START : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: vector table, corner sequences and random scoreboard for uart_tx_ctrl
module tb_uart_tx_ctrl;
  localparam int CD = 4;
  localparam int FL = 11 * CD;
  localparam int NR = 24;
  logic clk = 1'b0;
  logic rst, tx_valid_i, tx_ready_o, uart_tx, uart_cts, busy_o;
  logic [7:0] tx_data_i;
  logic [2:0] fifo_level_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];
  bit done;
  typedef struct {
    logic [7:0] d;
    logic       p;
  } vec_t;
  vec_t tv [7];

  uart_tx_ctrl #(.CLK_DIV(CD), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .uart_tx      (uart_tx),
    .uart_cts     (uart_cts),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // odd parity: the parity bit makes the total count of ones odd
  function automatic logic par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic logic bit_at(input logic [7:0] d, input logic p, input int i);
    int s;
    s = i / CD;
    return (s == 0) ? 1'b0 : (s <= 8) ? d[s-1] : (s == 9) ? p : 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_low(input int lim, output int n);
    n = 0;
    while (uart_tx !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
  endtask

  // records one whole frame starting at the first low sample, optionally raising CTS or pushing mid-frame
  task automatic cap(input logic [7:0] d, input logic p, input string nm, input int cts_at, input int push_at, input logic [7:0] pd);
    logic [FL-1:0] act, exp;
    for (int i = 0; i < FL; i++) begin
      exp[i] = bit_at(d, p, i);
      act[i] = uart_tx;
      if (i == cts_at) uart_cts = 1'b1;
      if (push_at >= 0 && i == push_at) begin
        tx_data_i  = pd;
        tx_valid_i = 1'b1;
      end
      if (push_at >= 0 && i == push_at + 1) begin
        tx_valid_i = 1'b0;
        chk("pushpop_level", fifo_level_o, 2);
      end
      tick();
    end
    chk(nm, act, exp);
  endtask

  task automatic tx_rand(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 60)) tick();
      tx_data_i  = 8'($urandom);
      tx_valid_i = 1'b1;
      for (int w = 0; w < 5000 && !tx_ready_o; w++) tick();
      if (tx_ready_o) q.push_back(tx_data_i);
      tick();
      tx_valid_i = 1'b0;
    end
  endtask

  // decodes frames from the line by sampling each bit in its middle
  task automatic rx_loop(input int n);
    logic [7:0] d, e;
    logic s, p, st;
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (uart_tx !== 1'b0 && w < 3000) begin
        tick();
        w++;
      end
      if (uart_tx !== 1'b0) begin
        chk("rx_timeout", w, 0);
        break;
      end
      repeat (CD / 2) tick();
      s = uart_tx;
      for (int b = 0; b < 8; b++) begin
        repeat (CD) tick();
        d[b] = uart_tx;
      end
      repeat (CD) tick();
      p = uart_tx;
      repeat (CD) tick();
      st = uart_tx;
      tick();
      chk("rx_start", s, 0);
      chk("rx_stop", st, 1);
      if (q.size() == 0) chk("rx_extra", d, 'x);
      else begin
        e = q.pop_front();
        chk("rx_data", d, e);
        chk("rx_parity", p, par(e));
      end
    end
    done = 1'b1;
  endtask

  initial begin
    int n, lows;
    logic [7:0] fb [5];
    tv[0] = '{8'hA5, 1'b1};
    tv[1] = '{8'h03, 1'b1};
    tv[2] = '{8'h07, 1'b0};
    tv[3] = '{8'h00, 1'b1};
    tv[4] = '{8'hFF, 1'b1};
    tv[5] = '{8'h80, 1'b0};
    tv[6] = '{8'h5B, 1'b0};
    fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 1'b1;
    uart_cts = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i = 8'h00;
    done = 1'b0;
    repeat (2) tick();
    chk("rst_tx", uart_tx, 1);
    chk("rst_ready", tx_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_level", fifo_level_o, 0);
    rst = 1'b0;
    uart_cts = 1'b0;
    repeat (3) tick();
    for (int v = 0; v < 7; v++) begin
      push(tv[v].d);
      wait_low(10, n);
      chk("start_latency", n, 2);
      cap(tv[v].d, tv[v].p, "table_frame", -1, -1, 8'h00);
      chk("idle_busy", busy_o, 0);
      chk("idle_tx", uart_tx, 1);
      tick();
    end
    uart_cts = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        chk("full_ready", tx_ready_o, 0);
        chk("full_level", fifo_level_o, 4);
      end
      push(fb[k]);
    end
    repeat (5) tick();
    chk("held_level", fifo_level_o, 4);
    chk("held_tx", uart_tx, 1);
    chk("held_busy", busy_o, 1);
    uart_cts = 1'b0;
    wait_low(10, n);
    chk("cts_latency", n, 4);
    chk("pop_ready", tx_ready_o, 1);
    chk("pop_level", fifo_level_o, 3);
    for (int k = 0; k < 4; k++) cap(fb[k], par(fb[k]), "b2b_frame", -1, -1, 8'h00);
    chk("b2b_end_tx", uart_tx, 1);
    chk("b2b_end_busy", busy_o, 0);
    push(8'hC3);
    push(8'h3C);
    wait_low(10, n);
    chk("cts_mid_start", n, 1);
    cap(8'hC3, par(8'hC3), "cts_mid_frame", 4 * CD + 1, -1, 8'h00);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (uart_tx === 1'b0) lows++;
      tick();
    end
    chk("cts_hold_lows", lows, 0);
    chk("cts_hold_level", fifo_level_o, 1);
    chk("cts_hold_busy", busy_o, 1);
    uart_cts = 1'b0;
    wait_low(10, n);
    chk("cts_resume", n, 4);
    cap(8'h3C, par(8'h3C), "cts_next_frame", -1, -1, 8'h00);
    uart_cts = 1'b1;
    repeat (3) tick();
    push(8'hA1);
    push(8'hB2);
    push(8'hC4);
    chk("pp_level3", fifo_level_o, 3);
    uart_cts = 1'b0;
    wait_low(10, n);
    chk("pp_start", n, 4);
    chk("pp_level2", fifo_level_o, 2);
    cap(8'hA1, par(8'hA1), "pp_frame_a", -1, FL - 2, 8'hD8);
    cap(8'hB2, par(8'hB2), "pp_frame_b", -1, -1, 8'h00);
    cap(8'hC4, par(8'hC4), "pp_frame_c", -1, -1, 8'h00);
    cap(8'hD8, par(8'hD8), "pp_frame_d", -1, -1, 8'h00);
    chk("pp_end_busy", busy_o, 0);
    fork
      tx_rand(NR);
      rx_loop(NR);
      begin
        while (!done) begin
          repeat ($urandom_range(5, 80)) tick();
          uart_cts = 1'($urandom_range(0, 1));
        end
        uart_cts = 1'b0;
      end
    join
    chk("rand_left", q.size(), 0);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) push(8'h90 + 8'(k));
    repeat (CD * 6 + 1 - 1) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_tx", uart_tx, 1);
    chk("mrst_level", fifo_level_o, 0);
    chk("mrst_ready", tx_ready_o, 1);
    chk("mrst_busy", busy_o, 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx === 1'b0) lows++;
      tick();
    end
    chk("mrst_quiet", lows, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
